// File: rtl/nrzi_destuff_decoder_if.sv
// Line-side and decoded-side signal bundle for the NRZI destuffing decoder.
// The slave modport is the decoder; the master modport is whatever feeds it.
interface nrzi_destuff_decoder_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_sending;
  logic       out_bit;
  logic       out_valid;
  logic       out_sending;
  logic       stuff_err;
  logic       pkt_end;
  logic       pkt_err;
  logic [1:0] dbg_state;

  // Handshake: a line bit is taken on a rising clock edge only when
  // in_valid and in_sending are both high; out_valid qualifies out_bit for
  // exactly one cycle and there is no backpressure in either direction.
  modport slave (
    input  in_bit, in_valid, in_sending,
    output out_bit, out_valid, out_sending, stuff_err, pkt_end, pkt_err,
    output dbg_state
  );

  modport master (
    output in_bit, in_valid, in_sending,
    input  out_bit, out_valid, out_sending, stuff_err, pkt_end, pkt_err,
    input  dbg_state
  );
endinterface

// File: rtl/nrzi_destuff_decoder.sv
// NRZI line decoder with bit unstuffing, stuff-error detection and packet
// framing. All outputs are registered one cycle behind the consumed line bit.
module nrzi_destuff_decoder #(
  parameter int   STUFF_RUN  = 6,
  parameter logic INIT_LEVEL = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  nrzi_destuff_decoder_if.slave  bus
);
  localparam int              RW      = $clog2(STUFF_RUN + 1);
  localparam logic [RW-1:0]   RUN_MAX = RW'(STUFF_RUN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          prev_level_q, prev_level_d;
  logic [RW-1:0] run_q, run_d;
  logic          err_seen_q, err_seen_d;
  logic          out_bit_q, out_bit_d;
  logic          out_valid_q, out_valid_d;
  logic          stuff_err_q, stuff_err_d;
  logic          out_sending_q;
  logic          pkt_end_q;
  logic          pkt_err_q;

  logic consume;
  logic dec_bit;

  assign consume = bus.in_valid & bus.in_sending;
  assign dec_bit = ~(bus.in_bit ^ prev_level_q);

  // IDLE keeps prev_level/run at their packet-start values, so a bit arriving
  // together with the in_sending rise decodes exactly like a DATA bit.
  always_comb begin
    state_d      = state_q;
    prev_level_d = prev_level_q;
    run_d        = run_q;
    err_seen_d   = err_seen_q;
    out_bit_d    = 1'b0;
    out_valid_d  = 1'b0;
    stuff_err_d  = 1'b0;
    if (!bus.in_sending) begin
      state_d      = S_IDLE;
      prev_level_d = INIT_LEVEL;
      run_d        = '0;
      err_seen_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DATA: begin
          state_d = S_DATA;
          if (consume) begin
            prev_level_d = bus.in_bit;
            if (run_q == RUN_MAX) begin
              if (dec_bit) begin
                stuff_err_d = 1'b1;
                err_seen_d  = 1'b1;
                state_d     = S_ERROR;
              end else begin
                run_d = '0;
              end
            end else begin
              out_valid_d = 1'b1;
              out_bit_d   = dec_bit;
              run_d       = dec_bit ? run_q + RW'(1) : '0;
            end
          end
        end
        S_ERROR: begin
          if (consume) prev_level_d = bus.in_bit;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      prev_level_q  <= INIT_LEVEL;
      run_q         <= '0;
      err_seen_q    <= 1'b0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      stuff_err_q   <= 1'b0;
      out_sending_q <= 1'b0;
      pkt_end_q     <= 1'b0;
      pkt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_level_q  <= prev_level_d;
      run_q         <= run_d;
      err_seen_q    <= err_seen_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      stuff_err_q   <= stuff_err_d;
      out_sending_q <= bus.in_sending;
      // err_seen_q still holds the finished packet's status on this edge.
      pkt_end_q     <= out_sending_q & ~bus.in_sending;
      pkt_err_q     <= out_sending_q & ~bus.in_sending & err_seen_q;
    end
  end

  assign bus.out_bit     = out_bit_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sending = out_sending_q;
  assign bus.stuff_err   = stuff_err_q;
  assign bus.pkt_end     = pkt_end_q;
  assign bus.pkt_err     = pkt_err_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_nrzi_destuff_decoder.sv
// Directed bench for nrzi_destuff_decoder: a default instance (A) and a
// STUFF_RUN=3 / INIT_LEVEL=0 instance (B) share one stimulus stream.
module tb_nrzi_destuff_decoder;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  nrzi_destuff_decoder_if if_a ();
  nrzi_destuff_decoder_if if_b ();

  nrzi_destuff_decoder dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  nrzi_destuff_decoder #(.STUFF_RUN(3), .INIT_LEVEL(1'b0)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: drive at negedge, sample 1 time unit after the next posedge
  task automatic cyc(input logic rstn, input logic b, input logic v, input logic s);
    @(negedge clock);
    reset_n        = rstn;
    if_a.in_bit    = b;
    if_a.in_valid  = v;
    if_a.in_sending = s;
    if_b.in_bit    = b;
    if_b.in_valid  = v;
    if_b.in_sending = s;
    @(posedge clock);
    #1;
  endtask

  task automatic line_bit(input logic b);
    cyc(1'b1, b, 1'b1, 1'b1);
  endtask

  task automatic gap_bit(input logic b);
    cyc(1'b1, b, 1'b0, 1'b1);
  endtask

  task automatic idle_cyc();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Mid-packet expectation; out_bit compared only when it is qualified.
  task automatic expect_bit(input bit sel, input logic v, input logic b, input logic se);
    check(sel ? "B out_valid" : "A out_valid", sel ? if_b.out_valid : if_a.out_valid, v);
    if (v) check(sel ? "B out_bit" : "A out_bit", sel ? if_b.out_bit : if_a.out_bit, b);
    check(sel ? "B stuff_err" : "A stuff_err", sel ? if_b.stuff_err : if_a.stuff_err, se);
    check(sel ? "B out_sending" : "A out_sending", sel ? if_b.out_sending : if_a.out_sending, 1'b1);
    check(sel ? "B pkt_end" : "A pkt_end", sel ? if_b.pkt_end : if_a.pkt_end, 1'b0);
  endtask

  task automatic expect_end(input bit sel, input logic pe, input logic perr);
    check(sel ? "B end.pkt_end" : "A end.pkt_end", sel ? if_b.pkt_end : if_a.pkt_end, pe);
    check(sel ? "B end.pkt_err" : "A end.pkt_err", sel ? if_b.pkt_err : if_a.pkt_err, perr);
    check(sel ? "B end.out_sending" : "A end.out_sending",
          sel ? if_b.out_sending : if_a.out_sending, 1'b0);
    check(sel ? "B end.out_valid" : "A end.out_valid", sel ? if_b.out_valid : if_a.out_valid, 1'b0);
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, " out_valid"},   if_a.out_valid,   1'b0);
    check({tag, " out_sending"}, if_a.out_sending, 1'b0);
    check({tag, " stuff_err"},   if_a.stuff_err,   1'b0);
    check({tag, " pkt_end"},     if_a.pkt_end,     1'b0);
    check({tag, " pkt_err"},     if_a.pkt_err,     1'b0);
    check({tag, " state"},       32'(if_a.dbg_state), 32'd0);
  endtask

  initial begin
    // Reset held for 3 cycles with a busy line.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      expect_all_zero("reset");
    end
    // First bit after release decodes against INIT_LEVEL=1: line 1 -> 1.
    line_bit(1'b1); expect_bit(0, 1'b1, 1'b1, 1'b0);
    idle_cyc();     expect_end(0, 1'b1, 1'b0);
    idle_cyc();     expect_end(0, 1'b0, 1'b0);

    // Basic decode with an in_valid gap: line 1,0,[gap 1],0,1,1 -> 1,0,-,1,0,1.
    line_bit(1'b1); expect_bit(0, 1'b1, 1'b1, 1'b0);
    line_bit(1'b0); expect_bit(0, 1'b1, 1'b0, 1'b0);
    gap_bit(1'b1);  expect_bit(0, 1'b0, 1'b0, 1'b0);
    line_bit(1'b0); expect_bit(0, 1'b1, 1'b1, 1'b0);
    line_bit(1'b1); expect_bit(0, 1'b1, 1'b0, 1'b0);
    line_bit(1'b1); expect_bit(0, 1'b1, 1'b1, 1'b0);
    idle_cyc();     expect_end(0, 1'b1, 1'b0);
    idle_cyc();

    // Destuff: six 1s, stuffed 0 dropped, then data 1.
    for (int i = 0; i < 6; i++) begin
      line_bit(1'b1); expect_bit(0, 1'b1, 1'b1, 1'b0);
    end
    line_bit(1'b0); expect_bit(0, 1'b0, 1'b0, 1'b0);
    line_bit(1'b0); expect_bit(0, 1'b1, 1'b1, 1'b0);
    idle_cyc();     expect_end(0, 1'b1, 1'b0);
    idle_cyc();

    // Stuff error: seventh consecutive 1, then three discarded bits.
    for (int i = 0; i < 6; i++) begin
      line_bit(1'b1); expect_bit(0, 1'b1, 1'b1, 1'b0);
    end
    line_bit(1'b1); expect_bit(0, 1'b0, 1'b0, 1'b1);
    line_bit(1'b0); expect_bit(0, 1'b0, 1'b0, 1'b0);
    line_bit(1'b1); expect_bit(0, 1'b0, 1'b0, 1'b0);
    line_bit(1'b0); expect_bit(0, 1'b0, 1'b0, 1'b0);
    idle_cyc();     expect_end(0, 1'b1, 1'b1);
    idle_cyc();     expect_end(0, 1'b0, 1'b0);

    // Packet A: line 0,0,0,0,0,0 -> 0 then five 1s, leaving line level 0.
    line_bit(1'b0); expect_bit(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      line_bit(1'b0); expect_bit(0, 1'b1, 1'b1, 1'b0);
    end
    idle_cyc();     expect_end(0, 1'b1, 1'b0);
    // Packet B right after a single idle cycle: restarts from level 1, run 0.
    for (int i = 0; i < 6; i++) begin
      line_bit(1'b1); expect_bit(0, 1'b1, 1'b1, 1'b0);
    end
    line_bit(1'b0); expect_bit(0, 1'b0, 1'b0, 1'b0);
    idle_cyc();     expect_end(0, 1'b1, 1'b0);
    idle_cyc();

    // Reset mid-packet: no pkt_end for the aborted packet, restart from INIT_LEVEL.
    line_bit(1'b0); expect_bit(0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    expect_all_zero("midreset");
    line_bit(1'b1); expect_bit(0, 1'b1, 1'b1, 1'b0);
    idle_cyc();     expect_end(0, 1'b1, 1'b0);
    idle_cyc();

    // Instance B (STUFF_RUN=3, INIT_LEVEL=0): line 0,0,0,1,0 -> 1,1,1,drop,0.
    for (int i = 0; i < 3; i++) begin
      line_bit(1'b0); expect_bit(1, 1'b1, 1'b1, 1'b0);
    end
    line_bit(1'b1); expect_bit(1, 1'b0, 1'b0, 1'b0);
    line_bit(1'b0); expect_bit(1, 1'b1, 1'b0, 1'b0);
    idle_cyc();     expect_end(1, 1'b1, 1'b0);
    idle_cyc();
    // Instance B stuff error: fourth consecutive 1.
    for (int i = 0; i < 3; i++) begin
      line_bit(1'b0); expect_bit(1, 1'b1, 1'b1, 1'b0);
    end
    line_bit(1'b0); expect_bit(1, 1'b0, 1'b0, 1'b1);
    idle_cyc();     expect_end(1, 1'b1, 1'b1);
    idle_cyc();

    // final report
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
